// File: rtl/sr_bist_if.sv
// sr_bist_if: serial link to the latch shift register plus BIST control/status bundle.
// Latency: none (wires only).
// Backpressure: none; master is the BIST stage, slave is the pin mux / shift-register side.
interface sr_bist_if #(
   parameter int LAT_W = 10,
   parameter int ERR_W = 8
);
   logic             run;
   logic             inj_err;
   logic             sr_rx;
   logic             sr_tx;
   logic             busy;
   logic             lat_valid;
   logic             timeout;
   logic [LAT_W-1:0] latency;
   logic             lock;
   logic [ERR_W-1:0] err_count;
   logic             err_sat;

   modport master (
      input  run, inj_err, sr_rx,
      output sr_tx, busy, lat_valid, timeout, latency, lock, err_count, err_sat
   );

   modport slave (
      output run, inj_err, sr_rx,
      input  sr_tx, busy, lat_valid, timeout, latency, lock, err_count, err_sat
   );
endinterface

// File: rtl/sr_bist.sv
// sr_bist: flushes the latch shift register, measures loop latency with a one-bit probe, then streams PRBS7 and counts errors.
// Latency: sr_tx changes only on bit boundaries; every status output is registered one clk after the deciding sample.
// Backpressure: none; free-running serial stream, run low aborts to IDLE with results held for readout.
module sr_bist #(
   parameter int BIT_PERIOD = 2,
   parameter int FLUSH_BITS = 80,
   parameter int LAT_W      = 10,
   parameter int ERR_W      = 8
) (
   input  logic      clk,
   input  logic      rst_n,
   sr_bist_if.master bus
);

   typedef enum logic [1:0] {IDLE, FLUSH, PROBE, PRBS} state_t;

   localparam int PH_W = $clog2(BIT_PERIOD);
   localparam int FC_W = $clog2(FLUSH_BITS + 1);
   localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(BIT_PERIOD - 1);
   localparam logic [FC_W-1:0]  FLUSH_END = FC_W'(FLUSH_BITS);
   localparam logic [LAT_W-1:0] LAT_MAX   = '1;
   localparam logic [ERR_W-1:0] ERR_MAX   = '1;
   localparam logic [ERR_W-1:0] ERR_NEAR  = ERR_MAX - ERR_W'(1);

   state_t           state;
   logic [PH_W-1:0]  ph;
   logic             run_q;
   logic             rx_q;
   logic [FC_W-1:0]  fcnt;
   logic [LAT_W-1:0] cnt;
   logic [LAT_W-1:0] wcnt;
   logic [6:0]       prbs;
   logic [6:0]       hist;
   logic [2:0]       hcnt;
   logic             chk_arm;
   logic             inj_pend;

   logic             bnd;
   logic             start;
   logic             prbs_bit;
   logic             sample;

   // bnd marks the clk whose closing edge wraps ph to 0, i.e. the bit boundary.
   assign bnd      = (ph == PH_LAST);
   assign start    = bus.run & ~run_q;
   assign prbs_bit = prbs[6] ^ prbs[5];
   // The checker only looks at rx_q once the first PRBS bit has had latency cycles to
   // travel the loop; from then on it samples the first clk each bit is visible.
   assign sample   = chk_arm && (wcnt == bus.latency) && (ph == bus.latency[PH_W-1:0]);

   // Free-running bit-phase counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ph <= '0;
      else        ph <= bnd ? '0 : ph + PH_W'(1);
   end

   // Input capture: sr_rx is asynchronous to the bit phase, run is edge-detected.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_q  <= 1'b0;
         run_q <= 1'b0;
      end else begin
         rx_q  <= bus.sr_rx;
         run_q <= bus.run;
      end
   end

   // Test sequencer: flush, latency probe, PRBS stream and checker; all status outputs live here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         fcnt          <= '0;
         cnt           <= '0;
         wcnt          <= '0;
         prbs          <= 7'h7F;
         hist          <= '0;
         hcnt          <= '0;
         chk_arm       <= 1'b0;
         inj_pend      <= 1'b0;
         bus.sr_tx     <= 1'b0;
         bus.busy      <= 1'b0;
         bus.lat_valid <= 1'b0;
         bus.timeout   <= 1'b0;
         bus.latency   <= '0;
         bus.lock      <= 1'b0;
         bus.err_count <= '0;
         bus.err_sat   <= 1'b0;
      end else if (state != IDLE && !bus.run) begin
         // Abort: results stay put so they can still be read out.
         state     <= IDLE;
         bus.sr_tx <= 1'b0;
         bus.busy  <= 1'b0;
         inj_pend  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.sr_tx <= 1'b0;
               if (start) begin
                  // Enter FLUSH at once so busy rises immediately; the flush
                  // bit count itself starts at the next bit boundary.
                  state         <= FLUSH;
                  bus.busy      <= 1'b1;
                  fcnt          <= '0;
                  prbs          <= 7'h7F;
                  hist          <= '0;
                  hcnt          <= '0;
                  wcnt          <= '0;
                  chk_arm       <= 1'b0;
                  inj_pend      <= 1'b0;
                  bus.lat_valid <= 1'b0;
                  bus.timeout   <= 1'b0;
                  bus.latency   <= '0;
                  bus.lock      <= 1'b0;
                  bus.err_count <= '0;
                  bus.err_sat   <= 1'b0;
               end
            end
            FLUSH: begin
               // The first boundary opens zero bit 1; the one after zero bit FLUSH_BITS launches the probe.
               if (bnd) begin
                  if (fcnt == FLUSH_END) begin
                     bus.sr_tx <= 1'b1;
                     cnt       <= '0;
                     state     <= PROBE;
                  end else begin
                     fcnt <= fcnt + FC_W'(1);
                  end
               end
            end
            PROBE: begin
               cnt <= cnt + LAT_W'(1);
               if (bnd) bus.sr_tx <= 1'b0;
               if (rx_q) begin
                  bus.latency   <= cnt;
                  bus.lat_valid <= 1'b1;
                  state         <= PRBS;
                  chk_arm       <= 1'b0;
                  wcnt          <= '0;
                  hcnt          <= '0;
               end else if (cnt == LAT_MAX) begin
                  bus.timeout <= 1'b1;
                  bus.busy    <= 1'b0;
                  bus.sr_tx   <= 1'b0;
                  state       <= IDLE;
               end
            end
            PRBS: begin
               // The generator state never sees the injected flip; only the line does.
               if (bnd) begin
                  prbs      <= {prbs[5:0], prbs_bit};
                  bus.sr_tx <= prbs_bit ^ (inj_pend | bus.inj_err);
                  inj_pend  <= 1'b0;
                  chk_arm   <= 1'b1;
               end else if (bus.inj_err) begin
                  inj_pend <= 1'b1;
               end
               if (chk_arm && wcnt != bus.latency) wcnt <= wcnt + LAT_W'(1);
               if (sample) begin
                  // The received bit always enters the history, so one line error
                  // is seen three times: directly and through both taps.
                  hist <= {hist[5:0], rx_q};
                  if (!bus.lock) begin
                     if (hcnt == 3'd6) bus.lock <= 1'b1;
                     hcnt <= hcnt + 3'd1;
                  end else if (rx_q != (hist[6] ^ hist[5])) begin
                     if (bus.err_count != ERR_MAX) bus.err_count <= bus.err_count + ERR_W'(1);
                     if (bus.err_count == ERR_NEAR) bus.err_sat <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sr_bist.sv
// tb_sr_bist: directed bench for sr_bist with switchable loop models (loopback, 128-clk delay, stuck-0, inverted).
// Latency: expected values are hand-derived per scenario.
// Backpressure: n/a; stimulus driven on negedge, outputs sampled on negedge.
module tb_sr_bist;

   logic clk = 1'b0;
   logic rst_n;
   logic [1:0]   lmode;
   logic [127:0] dl = '0;

   int n_run  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sr_bist_if #(.LAT_W(10), .ERR_W(8)) bus ();

   sr_bist #(
      .BIT_PERIOD(2),
      .FLUSH_BITS(80),
      .LAT_W(10),
      .ERR_W(8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   // 128-clk delay line standing in for the latch chain.
   always_ff @(posedge clk) dl <= {dl[126:0], bus.sr_tx};

   // Loop model select.
   always_comb begin
      case (lmode)
         2'd0:    bus.sr_rx = bus.sr_tx;
         2'd1:    bus.sr_rx = dl[127];
         2'd2:    bus.sr_rx = 1'b0;
         default: bus.sr_rx = ~bus.sr_tx;
      endcase
   end

   task automatic check(input string tag, input int act, input int exp);
      n_run++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", tag, act, exp);
      end
   endtask

   function automatic logic sig(input int w);
      case (w)
         0:       return bus.lat_valid;
         1:       return bus.lock;
         2:       return bus.timeout;
         default: return bus.sr_tx;
      endcase
   endfunction

   // Counts negedges until the selected output is seen high, bounded by max.
   task automatic wait_for(input int w, input int max, output int n);
      n = 0;
      while (!sig(w) && n < max) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n       = 1'b0;
      bus.run     = 1'b0;
      bus.inj_err = 1'b0;
      lmode       = 2'd0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_sr_tx",     int'(bus.sr_tx),     0);
      check("rst_busy",      int'(bus.busy),      0);
      check("rst_lat_valid", int'(bus.lat_valid), 0);
      check("rst_timeout",   int'(bus.timeout),   0);
      check("rst_latency",   int'(bus.latency),   0);
      check("rst_lock",      int'(bus.lock),      0);
      check("rst_err_count", int'(bus.err_count), 0);
      check("rst_err_sat",   int'(bus.err_sat),   0);
      rst_n = 1'b1;
      @(negedge clk);

      // Direct loopback: latency 1, lock 16 clk after lat_valid, clean stream
      bus.run = 1'b1;
      @(negedge clk);
      check("lb_busy", int'(bus.busy), 1);
      wait_for(0, 400, n);
      check("lb_lat_valid", int'(bus.lat_valid), 1);
      check("lb_latency",   int'(bus.latency),   1);
      check("lb_timeout",   int'(bus.timeout),   0);
      wait_for(1, 100, n);
      check("lb_lock_delay", n, 16);
      repeat (2000) @(negedge clk);
      check("lb_lock_held", int'(bus.lock),      1);
      check("lb_err0",      int'(bus.err_count), 0);

      // Single injected error -> exactly 3 counted
      bus.inj_err = 1'b1;
      @(negedge clk);
      bus.inj_err = 1'b0;
      repeat (100) @(negedge clk);
      check("inj_err3",    int'(bus.err_count), 3);
      check("inj_err_sat", int'(bus.err_sat),   0);

      // Abort mid-PRBS: idle next cycle, results held
      bus.run = 1'b0;
      @(negedge clk);
      check("abort_busy",    int'(bus.busy),      0);
      check("abort_sr_tx",   int'(bus.sr_tx),     0);
      check("abort_lock",    int'(bus.lock),      1);
      check("abort_err",     int'(bus.err_count), 3);
      check("abort_latency", int'(bus.latency),   1);
      check("abort_lat_vld", int'(bus.lat_valid), 1);
      repeat (20) @(negedge clk);
      check("abort_tx_idle", int'(bus.sr_tx), 0);

      // 128-clk delay chain: restart clears, latency 129, clean stream
      lmode   = 2'd1;
      bus.run = 1'b1;
      @(negedge clk);
      check("dl_clr_lock", int'(bus.lock),      0);
      check("dl_clr_err",  int'(bus.err_count), 0);
      check("dl_clr_lv",   int'(bus.lat_valid), 0);
      wait_for(0, 1000, n);
      check("dl_lat_valid", int'(bus.lat_valid), 1);
      check("dl_latency",   int'(bus.latency),   129);
      wait_for(1, 1000, n);
      check("dl_lock", int'(bus.lock), 1);
      repeat (4000) @(negedge clk);
      check("dl_err0", int'(bus.err_count), 0);

      // Inverted loop after lock: every bit wrong, saturate at 255 without wrap
      bus.run = 1'b0;
      @(negedge clk);
      lmode   = 2'd0;
      bus.run = 1'b1;
      wait_for(1, 600, n);
      check("inv_lock", int'(bus.lock), 1);
      lmode = 2'd3;
      repeat (400) @(negedge clk);
      check("inv_not_sat_yet", int'(bus.err_sat), 0);
      repeat (1000) @(negedge clk);
      check("inv_err_255", int'(bus.err_count), 255);
      check("inv_err_sat", int'(bus.err_sat),   1);
      repeat (200) @(negedge clk);
      check("inv_no_wrap", int'(bus.err_count), 255);

      // Stuck-0 loop: probe launched after 80 zero bits, timeout 1024 clk after probe
      bus.run = 1'b0;
      @(negedge clk);
      lmode   = 2'd2;
      bus.run = 1'b1;
      wait_for(3, 400, n);
      check("flush_len", int'(n >= 162 && n <= 163), 1);
      wait_for(2, 1100, n);
      check("to_delay",     n,                   1024);
      check("to_timeout",   int'(bus.timeout),   1);
      check("to_lat_valid", int'(bus.lat_valid), 0);
      check("to_busy",      int'(bus.busy),      0);
      check("to_lock",      int'(bus.lock),      0);
      check("to_err",       int'(bus.err_count), 0);
      check("to_err_sat",   int'(bus.err_sat),   0);

      // Async reset mid-test clears outputs without a clock edge
      bus.run = 1'b0;
      @(negedge clk);
      lmode   = 2'd0;
      bus.run = 1'b1;
      wait_for(1, 600, n);
      check("ar_lock_before", int'(bus.lock), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_lock",      int'(bus.lock),      0);
      check("ar_busy",      int'(bus.busy),      0);
      check("ar_lat_valid", int'(bus.lat_valid), 0);
      check("ar_latency",   int'(bus.latency),   0);
      check("ar_sr_tx",     int'(bus.sr_tx),     0);
      bus.run = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
